// File: rtl/buzzer_pkg.sv
// ---------------------------------------------------------------------------
// buzzer_pkg : shared types and constants for the buzzer scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package buzzer_pkg;

  localparam int         NREQ    = 3;
  localparam logic [1:0] IDLE_ID = 2'd3;
  localparam int         MIN_DIV = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic int pre_width(input int clk_hz);
    if (clk_hz / 1000 <= 2) return 1;
    return $clog2(clk_hz / 1000);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tone_gen.sv
// ---------------------------------------------------------------------------
// tone_gen : square wave with half-period i_div clocks, cleared while disabled
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tone_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_bp
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_bp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_bp  <= 1'b0;
    end else if (!i_en) begin
      r_cnt <= '0;
      r_bp  <= 1'b0;
    end else if (r_cnt >= i_div - 1'b1) begin
      r_cnt <= '0;
      r_bp  <= ~r_bp;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_bp = r_bp;

endmodule

`default_nettype wire

// File: rtl/buzzer_sched.sv
// ---------------------------------------------------------------------------
// buzzer_sched : fixed-priority sharing of BP1 between NREQ tone requesters
// Optional macro BUZZER_PREEMPT_EN lets a higher-priority request abort PLAY.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module buzzer_sched
  import buzzer_pkg::*;
#(
  parameter int CLK_HZ = 48_000_000,
  parameter int DIV_W  = 16,
  parameter int DUR_W  = 12,
  parameter int GAP_MS = 10
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DIV_W-1:0] req_div,
  input  logic [NREQ*DUR_W-1:0] req_dur,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [1:0]            cur_id,
  output logic                  BP1
);

  localparam int                 c_PRE_W   = pre_width(CLK_HZ);
  localparam int                 c_GAP_W   = $clog2(GAP_MS + 1);
  localparam int                 c_MS_W    = (DUR_W > c_GAP_W) ? DUR_W : c_GAP_W;
  localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(CLK_HZ / 1000 - 1);
  localparam logic [c_MS_W-1:0]  c_GAP     = c_MS_W'(GAP_MS);

  state_t             r_state, w_next;
  logic [1:0]         r_cur;
  logic [DIV_W-1:0]   r_div;
  logic [DUR_W-1:0]   r_dur;
  logic [c_PRE_W-1:0] r_pre;
  logic [c_MS_W-1:0]  r_ms;

  logic               w_any, w_grant, w_done, w_pre_wrap, w_tone;
  logic [1:0]         w_idx, w_done_id;
  logic [DIV_W-1:0]   w_sel_div, w_div_clamped;
  logic [DUR_W-1:0]   w_sel_dur;
  logic [c_MS_W-1:0]  w_ms_inc;

  // Requests are masked while reset is held so no grant leaks out combinationally.
  assign w_any = RST_N & (|req);

  always_comb begin
    w_idx = 2'd0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) w_idx = 2'(i);
    end
  end

  assign w_sel_div     = req_div[w_idx*DIV_W +: DIV_W];
  assign w_sel_dur     = req_dur[w_idx*DUR_W +: DUR_W];
  assign w_div_clamped = (w_sel_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : w_sel_div;
  assign w_pre_wrap    = (r_pre == c_PRE_MAX);
  assign w_ms_inc      = r_ms + 1'b1;

`ifdef BUZZER_PREEMPT_EN
  logic w_preempt;
  always_comb begin
    w_preempt = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && (2'(i) < r_cur)) w_preempt = 1'b1;
    end
  end
`endif

  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    w_done    = 1'b0;
    w_done_id = r_cur;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_grant = 1'b1;
          if (w_sel_dur == '0) begin
            w_done    = 1'b1;
            w_done_id = w_idx;
            w_next    = ST_GAP;
          end else begin
            w_next = ST_PLAY;
          end
        end
      end
      ST_PLAY: begin
        if (w_pre_wrap && (w_ms_inc == c_MS_W'(r_dur))) begin
          w_done = 1'b1;
          w_next = ST_GAP;
        end
`ifdef BUZZER_PREEMPT_EN
        // Aborted tone skips the gap so the preemptor is granted next cycle.
        if (w_preempt) begin
          w_done = 1'b1;
          w_next = ST_IDLE;
        end
`endif
      end
      ST_GAP: begin
        if ((GAP_MS == 0) || (w_pre_wrap && (w_ms_inc == c_GAP))) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_cur   <= IDLE_ID;
      r_div   <= '0;
      r_dur   <= '0;
      r_pre   <= '0;
      r_ms    <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_cur <= w_idx;
        r_div <= w_div_clamped;
        r_dur <= w_sel_dur;
      end else if (w_next == ST_IDLE) begin
        r_cur <= IDLE_ID;
      end
      if ((w_next != r_state) || (r_state == ST_IDLE)) begin
        r_pre <= '0;
        r_ms  <= '0;
      end else if (w_pre_wrap) begin
        r_pre <= '0;
        r_ms  <= w_ms_inc;
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  tone_gen #(.DIV_W(DIV_W)) u_tone (
    .clk   (CLK),
    .rst_n (RST_N),
    .i_en  (r_state == ST_PLAY),
    .i_div (r_div),
    .o_bp  (w_tone)
  );

  assign ack    = w_grant ? (NREQ'(1) << w_idx) : '0;
  assign done   = w_done ? (NREQ'(1) << w_done_id) : '0;
  assign busy   = (r_state != ST_IDLE);
  assign cur_id = w_grant ? w_idx : r_cur;
  assign BP1    = w_tone & (r_state == ST_PLAY) & ~w_done;

endmodule

`default_nettype wire

// File: tb/tb_buzzer_sched.sv
// ---------------------------------------------------------------------------
// tb_buzzer_sched : scoreboard bench for buzzer_sched at 48 cycles/ms, GAP_MS=2
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_buzzer_sched;

  localparam int MS  = 48;
  localparam int GAP = 2 * MS;

  typedef struct {
    int         cyc;
    logic [2:0] ack;
    logic [2:0] done;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = '0;
  logic [47:0] req_div = '0;
  logic [35:0] req_dur = '0;
  logic [2:0]  ack, done;
  logic        busy;
  logic [1:0]  cur_id;
  logic        BP1;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  ev_t  sb[$];
  ev_t  mon_e;

  buzzer_sched #(
    .CLK_HZ (48_000),
    .DIV_W  (16),
    .DUR_W  (12),
    .GAP_MS (2)
  ) dut (
    .CLK     (clk),
    .RST_N   (rst_n),
    .req     (req),
    .req_div (req_div),
    .req_dur (req_dur),
    .ack     (ack),
    .done    (done),
    .busy    (busy),
    .cur_id  (cur_id),
    .BP1     (BP1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every ack/done pulse must match the next expected event in time.
  always @(negedge clk) begin
    if (mon_en) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        mon_e = sb.pop_front();
        n_chk++; n_fail++;
        $display("FAIL missed_event cyc=%0d exp_ack=%b exp_done=%b", mon_e.cyc, mon_e.ack, mon_e.done);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        mon_e = sb.pop_front();
        n_chk++;
        if (ack !== mon_e.ack || done !== mon_e.done) begin
          n_fail++;
          $display("FAIL event cyc=%0d ack=%b done=%b exp_ack=%b exp_done=%b",
                   cyc, ack, done, mon_e.ack, mon_e.done);
        end
      end else if (ack !== 3'b000 || done !== 3'b000) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_pulse cyc=%0d ack=%b done=%b exp=000/000", cyc, ack, done);
      end
    end
  end

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_chk++; if (ack !== 3'b000)   begin n_fail++; $display("FAIL reset_ack got=%b exp=000", ack); end
    n_chk++; if (done !== 3'b000)  begin n_fail++; $display("FAIL reset_done got=%b exp=000", done); end
    n_chk++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_chk++; if (cur_id !== 2'd3)  begin n_fail++; $display("FAIL reset_cur_id got=%0d exp=3", cur_id); end
    n_chk++; if (BP1 !== 1'b0)     begin n_fail++; $display("FAIL reset_bp1 got=%b exp=0", BP1); end
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  // One isolated tone: grant, waveform, gap and return to idle.
  task automatic run_tone(input int id, input int div, input int dur);
    int k, ed, exp_bp;
    @(posedge clk); #1;
    req_div[id*16 +: 16] = 16'(div);
    req_dur[id*12 +: 12] = 12'(dur);
    req = 3'(1 << id);
    k = cyc;
    sb.push_back('{k, 3'(1 << id), (dur == 0) ? 3'(1 << id) : 3'b000});
    if (dur > 0) sb.push_back('{k + dur*MS, 3'b000, 3'(1 << id)});
    #1;
    n_chk++; if (cur_id !== 2'(id)) begin n_fail++; $display("FAIL grant_cur_id got=%0d exp=%0d", cur_id, id); end
    @(posedge clk); #1;
    req = '0;
    ed = (div < 2) ? 2 : div;
    for (int j = 0; j < dur*MS; j++) begin
      @(negedge clk);
      exp_bp = (j == dur*MS - 1) ? 0 : ((j / ed) % 2);
      n_chk++;
      if (BP1 !== 1'(exp_bp) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL play_bp1 div=%0d j=%0d bp1=%b busy=%b exp_bp1=%0d exp_busy=1", div, j, BP1, busy, exp_bp);
      end
    end
    for (int g = 0; g < GAP; g++) begin
      @(negedge clk);
      n_chk++;
      if (BP1 !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL gap g=%0d bp1=%b busy=%b exp_bp1=0 exp_busy=1", g, BP1, busy);
      end
    end
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || cur_id !== 2'd3) begin
      n_fail++;
      $display("FAIL idle_after_gap busy=%b cur_id=%0d exp_busy=0 exp_cur_id=3", busy, cur_id);
    end
  endtask

  task automatic test_single;
    run_tone(1, 6, 3);
  endtask

  task automatic test_zero_dur;
    run_tone(0, 5, 0);
  endtask

  task automatic test_clamp;
    run_tone(1, 0, 1);
    run_tone(1, 1, 1);
  endtask

  task automatic test_priority;
    int k;
    @(posedge clk); #1;
    req_div[0 +: 16]  = 16'd4;  req_dur[0 +: 12]  = 12'd1;
    req_div[32 +: 16] = 16'd4;  req_dur[24 +: 12] = 12'd1;
    req = 3'b101;
    k = cyc;
    sb.push_back('{k,           3'b001, 3'b000});
    sb.push_back('{k + MS,      3'b000, 3'b001});
    sb.push_back('{k + 145,     3'b100, 3'b000});
    sb.push_back('{k + 145 + MS, 3'b000, 3'b100});
    for (int c = 1; c <= 290; c++) begin
      @(posedge clk); #1;
      if (c == 1)   req = 3'b100;
      if (c == 146) req = 3'b000;
      @(negedge clk);
      if ((c >= 49 && c <= 144) || (c >= 194 && c <= 289)) begin
        n_chk++;
        if (BP1 !== 1'b0) begin n_fail++; $display("FAIL prio_gap_bp1 c=%0d got=%b exp=0", c, BP1); end
      end
      if (c == 145) begin
        n_chk++;
        if (cur_id !== 2'd2) begin n_fail++; $display("FAIL prio_second_id got=%0d exp=2", cur_id); end
      end
      if (c == 290) begin
        n_chk++;
        if (busy !== 1'b0 || cur_id !== 2'd3) begin
          n_fail++;
          $display("FAIL prio_idle busy=%b cur_id=%0d exp_busy=0 exp_cur_id=3", busy, cur_id);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int k;
    @(posedge clk); #1;
    req_div[16 +: 16] = 16'd6;
    req_dur[12 +: 12] = 12'd3;
    req = 3'b010;
    k = cyc;
    sb.push_back('{k, 3'b010, 3'b000});
    repeat (55) begin @(posedge clk); #1; end
    n_chk++;
    if (BP1 !== 1'b1) begin n_fail++; $display("FAIL pre_reset_bp1 got=%b exp=1", BP1); end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (BP1 !== 1'b0 || busy !== 1'b0 || ack !== 3'b000 || done !== 3'b000 || cur_id !== 2'd3) begin
      n_fail++;
      $display("FAIL async_reset bp1=%b busy=%b ack=%b done=%b cur_id=%0d exp=0/0/000/000/3",
               BP1, busy, ack, done, cur_id);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = cyc;
    sb.push_back('{k,          3'b010, 3'b000});
    sb.push_back('{k + 3*MS,   3'b000, 3'b010});
    @(posedge clk); #1;
    req = '0;
    repeat (3*MS + GAP) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || cur_id !== 2'd3) begin
      n_fail++;
      $display("FAIL regrant_idle busy=%b cur_id=%0d exp_busy=0 exp_cur_id=3", busy, cur_id);
    end
  endtask

  task automatic test_preempt;
    int k, t_done2, t_ack0, t_end;
    @(posedge clk); #1;
    req_div[32 +: 16] = 16'd4;  req_dur[24 +: 12] = 12'd10;
    req_div[0 +: 16]  = 16'd8;  req_dur[0 +: 12]  = 12'd1;
    req = 3'b100;
    k = cyc;
`ifdef BUZZER_PREEMPT_EN
    t_done2 = k + 1 + 4*MS;
    t_ack0  = t_done2 + 1;
`else
    t_done2 = k + 10*MS;
    t_ack0  = t_done2 + GAP + 1;
`endif
    t_end = t_ack0 + MS + GAP + 1;
    sb.push_back('{k,           3'b100, 3'b000});
    sb.push_back('{t_done2,     3'b000, 3'b100});
    sb.push_back('{t_ack0,      3'b001, 3'b000});
    sb.push_back('{t_ack0 + MS, 3'b000, 3'b001});
    for (int c = 1; c <= t_end - k; c++) begin
      @(posedge clk); #1;
      if (c == 1)            req = 3'b000;
      if (c == 1 + 4*MS)     req = 3'b001;
      if (k + c == t_ack0 + 1) req = 3'b000;
      @(negedge clk);
      if (k + c == t_done2) begin
        n_chk++;
        if (BP1 !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL tone_end_bp1 bp1=%b busy=%b exp_bp1=0 exp_busy=1", BP1, busy);
        end
      end
      if (k + c == t_ack0 + 1) begin
        n_chk++;
        if (busy !== 1'b1 || cur_id !== 2'd0) begin
          n_fail++;
          $display("FAIL second_play busy=%b cur_id=%0d exp_busy=1 exp_cur_id=0", busy, cur_id);
        end
      end
      if (k + c == t_end) begin
        n_chk++;
        if (busy !== 1'b0 || cur_id !== 2'd3) begin
          n_fail++;
          $display("FAIL preempt_idle busy=%b cur_id=%0d exp_busy=0 exp_cur_id=3", busy, cur_id);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_priority;
    test_zero_dur;
    test_clamp;
    test_reset_mid;
    test_preempt;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
